// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-master dpram port-A arbiter.
package mem_arb_pkg;

   localparam int AW_DEF       = 10;
   localparam int DW_DEF       = 16;
   localparam int HOLD_MAX_DEF = 8;

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t;

   typedef logic midx_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way request picker; round-robin on ties when MEM_ARB_RR_EN is defined,
// fixed priority to master 0 otherwise.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  midx_t      last,
   output midx_t      sel
);

`ifdef MEM_ARB_RR_EN
   always_comb begin
      if (req == 2'b11) sel = ~last;
      else              sel = (req == 2'b10);
   end
`else
   logic unused_last;
   assign unused_last = last;
   assign sel         = (req == 2'b10);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for dpram port A with lock/hold and bounded starvation.
// Optional round-robin tie-break via the MEM_ARB_RR_EN macro.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int HOLD_MAX = HOLD_MAX_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m1_req,
   input  logic          m0_we,
   input  logic          m1_we,
   input  logic          m0_lock,
   input  logic          m1_lock,
   input  logic [AW-1:0] m0_addr,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic [DW-1:0] m1_wdata,
   output logic          m0_gnt,
   output logic          m1_gnt,
   output logic          m0_rvalid,
   output logic          m1_rvalid,
   output logic [DW-1:0] m0_rdata,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_en,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   input  logic [DW-1:0] mem_q
);

   localparam int CW = $clog2(HOLD_MAX + 1);

   arb_state_t    state;
   midx_t         last;
   logic [CW-1:0] hold_cnt;
   logic [1:0]    rd_pend;
   logic          hand_vld;
   midx_t         hand_to;

   midx_t         pick;
   midx_t         sel;
   logic          gnt;
   logic          sel_we;
   logic          sel_lock;
   logic          oth_req;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic [CW-1:0] base_cnt;

   rr_pick2 u_pick (
      .req  ({m1_req, m0_req}),
      .last (last),
      .sel  (pick)
   );

   // Lock owner first, then a pending forced handover, then the picker.
   always_comb begin
      sel = pick;
      if (state == LOCK0 && m0_req)                           sel = 1'b0;
      else if (state == LOCK1 && m1_req)                      sel = 1'b1;
      else if (hand_vld && (hand_to ? m1_req : m0_req))       sel = hand_to;
      gnt       = !reset && (sel ? m1_req : m0_req);
      sel_we    = sel ? m1_we    : m0_we;
      sel_lock  = sel ? m1_lock  : m0_lock;
      sel_addr  = sel ? m1_addr  : m0_addr;
      sel_wdata = sel ? m1_wdata : m0_wdata;
      oth_req   = sel ? m0_req   : m1_req;
      base_cnt  = ((state == LOCK0 && !sel) || (state == LOCK1 && sel)) ? hold_cnt : '0;
   end

   assign m0_gnt    = gnt && !sel;
   assign m1_gnt    = gnt && sel;
   assign mem_en    = gnt && sel_we;
   assign mem_addr  = gnt ? sel_addr  : '0;
   assign mem_data  = gnt ? sel_wdata : '0;
   assign m0_rvalid = rd_pend[0] && !reset;
   assign m1_rvalid = rd_pend[1] && !reset;
   assign m0_rdata  = mem_q;
   assign m1_rdata  = mem_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         last     <= 1'b1;
         hold_cnt <= '0;
         rd_pend  <= '0;
         hand_vld <= 1'b0;
         hand_to  <= 1'b0;
      end else begin
         rd_pend  <= {m1_gnt && !m1_we, m0_gnt && !m0_we};
         hand_vld <= 1'b0;
         if (!gnt) begin
            state    <= IDLE;
            hold_cnt <= '0;
         end else if (sel_lock && (!oth_req || int'(base_cnt) + 1 < HOLD_MAX)) begin
            state    <= sel ? LOCK1 : LOCK0;
            hold_cnt <= oth_req ? base_cnt + 1'b1 : base_cnt;
         end else begin
            // Unlocked transfer, or the hold budget ran out with the partner waiting.
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= sel;
            if (sel_lock) begin
               hand_vld <= 1'b1;
               hand_to  <= ~sel;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random bench for mem_arbiter with a behavioural dpram port A.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
   logic [9:0]  m0_addr, m1_addr;
   logic [15:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [15:0] m0_rdata, m1_rdata;
   logic        mem_en;
   logic [9:0]  mem_addr;
   logic [15:0] mem_data;
   logic [15:0] mem_q;

   logic [15:0] dp [0:1023];
   logic [15:0] ref_mem [0:1023];

   typedef struct {
      logic        m;
      logic [15:0] d;
   } sb_t;
   sb_t sbq[$];

   int   n_chk  = 0;
   int   n_pass = 0;
   logic g0, g1;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (m0_req),
      .m1_req    (m1_req),
      .m0_we     (m0_we),
      .m1_we     (m1_we),
      .m0_lock   (m0_lock),
      .m1_lock   (m1_lock),
      .m0_addr   (m0_addr),
      .m1_addr   (m1_addr),
      .m0_wdata  (m0_wdata),
      .m1_wdata  (m1_wdata),
      .m0_gnt    (m0_gnt),
      .m1_gnt    (m1_gnt),
      .m0_rvalid (m0_rvalid),
      .m1_rvalid (m1_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_rdata  (m1_rdata),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_q     (mem_q)
   );

   always_ff @(posedge clk) begin
      if (mem_en) dp[mem_addr] <= mem_data;
      mem_q <= dp[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic set0(input logic r, input logic w, input logic l,
                       input logic [9:0] a, input logic [15:0] d);
      m0_req = r; m0_we = w; m0_lock = l; m0_addr = a; m0_wdata = d;
   endtask

   task automatic set1(input logic r, input logic w, input logic l,
                       input logic [9:0] a, input logic [15:0] d);
      m1_req = r; m1_we = w; m1_lock = l; m1_addr = a; m1_wdata = d;
   endtask

   task automatic tick(input logic cg, input logic e0, input logic e1);
      sb_t ent;
      @(negedge clk);
      g0 = m0_gnt;
      g1 = m1_gnt;
      if (reset) begin
         chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
         chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
         chk("rst_mem", 32'({mem_en, mem_addr, mem_data}), 32'd0);
         sbq.delete();
      end else begin
         if (sbq.size() > 0) begin
            ent = sbq.pop_front();
            chk("rvalid", 32'({m0_rvalid, m1_rvalid}), ent.m ? 32'd1 : 32'd2);
            chk(ent.m ? "m1_rdata" : "m0_rdata", 32'(ent.m ? m1_rdata : m0_rdata), 32'(ent.d));
         end else begin
            chk("rvalid_idle", 32'({m0_rvalid, m1_rvalid}), 32'd0);
         end
         chk("gnt_legal", 32'({m0_gnt && m1_gnt, m0_gnt && !m0_req, m1_gnt && !m1_req}), 32'd0);
         if (cg) chk("gnt", 32'({m0_gnt, m1_gnt}), 32'({e0, e1}));
         if (m0_gnt) begin
            chk("mem_m0", 32'({mem_en, mem_addr, mem_data}), 32'({m0_we, m0_addr, m0_we ? m0_wdata : m0_wdata}));
            if (m0_we) ref_mem[m0_addr] = m0_wdata;
            else       sbq.push_back('{m: 1'b0, d: ref_mem[m0_addr]});
         end else if (m1_gnt) begin
            chk("mem_m1", 32'({mem_en, mem_addr, mem_data}), 32'({m1_we, m1_addr, m1_wdata}));
            if (m1_we) ref_mem[m1_addr] = m1_wdata;
            else       sbq.push_back('{m: 1'b1, d: ref_mem[m1_addr]});
         end else begin
            chk("mem_idle", 32'({mem_en, mem_addr, mem_data}), 32'd0);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   done;
      int   cyc;
      logic p0, p1;
      reset = 1'b1;
      set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
      set1(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
      @(posedge clk);
      #1;
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      reset = 1'b0;

      // single write then read
      set0(1'b1, 1'b1, 1'b0, 10'h005, 16'hBEEF); tick(1'b1, 1'b1, 1'b0);
      set0(1'b1, 1'b0, 1'b0, 10'h005, 16'h0000); tick(1'b1, 1'b1, 1'b0);
      set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000); tick(1'b1, 1'b0, 1'b0);
      set1(1'b1, 1'b1, 1'b0, 10'h006, 16'h1234); tick(1'b1, 1'b0, 1'b1);
      set1(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000); tick(1'b1, 1'b0, 1'b0);

      // tie from reset
      reset = 1'b1; tick(1'b1, 1'b0, 1'b0); reset = 1'b0;
      set0(1'b1, 1'b0, 1'b0, 10'h005, 16'h0000);
      set1(1'b1, 1'b0, 1'b0, 10'h006, 16'h0000);
`ifdef MEM_ARB_RR_EN
      tick(1'b1, 1'b1, 1'b0); tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0); tick(1'b1, 1'b0, 1'b1);
`else
      tick(1'b1, 1'b1, 1'b0); tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0); tick(1'b1, 1'b1, 1'b0);
`endif
      set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
      set1(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
      tick(1'b1, 1'b0, 1'b0);

      // locked m0 against waiting m1: eight grants then handover
      set0(1'b1, 1'b0, 1'b1, 10'h005, 16'h0000);
      set1(1'b1, 1'b0, 1'b0, 10'h006, 16'h0000);
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      set1(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
      set0(1'b1, 1'b0, 1'b0, 10'h005, 16'h0000); tick(1'b1, 1'b1, 1'b0);
      set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000); tick(1'b1, 1'b0, 1'b0);

      // locked m0 with idle partner
      set0(1'b1, 1'b0, 1'b1, 10'h005, 16'h0000);
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b1, 1'b0);
         chk("hold_cnt_idle", 32'(dut.hold_cnt), 32'd0);
      end
      set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);

      // reset while an m1 read is in flight
      set1(1'b1, 1'b0, 1'b0, 10'h006, 16'h0000); tick(1'b1, 1'b0, 1'b1);
      reset = 1'b1;
      set0(1'b1, 1'b0, 1'b0, 10'h005, 16'h0000); tick(1'b1, 1'b0, 1'b0);
      reset = 1'b0;
      tick(1'b1, 1'b1, 1'b0);
      set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000); tick(1'b1, 1'b0, 1'b1);
      set1(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000); tick(1'b1, 1'b0, 1'b0);

      // random cross-check over a small window of addresses
      for (int i = 0; i < 16; i++) begin
         set0(1'b1, 1'b1, 1'b0, 10'(16 + i), 16'($urandom));
         tick(1'b1, 1'b1, 1'b0);
      end
      set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
      tick(1'b1, 1'b0, 1'b0);
      done = 0; cyc = 0; p0 = 1'b0; p1 = 1'b0;
      while (done < 160 && cyc < 3000) begin
         if (!p0 && $urandom_range(0, 9) < 7) begin
            p0 = 1'b1;
            set0(1'b1, 1'($urandom_range(0, 1)), 1'b0, 10'($urandom_range(16, 31)), 16'($urandom));
         end
         if (!p1 && $urandom_range(0, 9) < 7) begin
            p1 = 1'b1;
            set1(1'b1, 1'($urandom_range(0, 1)), 1'b0, 10'($urandom_range(16, 31)), 16'($urandom));
         end
         tick(1'b0, 1'b0, 1'b0);
         if (g0) begin p0 = 1'b0; m0_req = 1'b0; done++; end
         if (g1) begin p1 = 1'b0; m1_req = 1'b0; done++; end
         cyc++;
      end
      chk("rand_done", 32'(done >= 160), 32'd1);
      set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
      set1(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-master arbiter in front of port A of the 1K×16 `dpram`.
- The CPU (m0) and the loader/DMA engine (m1) share the port.
- One transfer is granted per clock. A master may hold ownership across consecutive transfers with a lock signal, bounded by a starvation counter.
- Read data returns one cycle after grant, tagged to the requesting master.

## Interface
- `AW`, 10, address width (matches `dpram` depth)
- `DW`, 16, data width
- `HOLD_MAX`, 8, max consecutive locked grants while the other master waits (≥1)

- Clock and reset: one clock, `clk`. Reset `reset` is synchronous and active-high.
- `clk` in 1 — rising-edge clock
- `reset` in 1 — synchronous, active-high
- `m0_req`, `m1_req` in 1 — transfer request
- `m0_we`, `m1_we` in 1 — 1 = write, 0 = read
- `m0_lock`, `m1_lock` in 1 — keep ownership after this transfer
- `m0_addr`, `m1_addr` in AW — word address
- `m0_wdata`, `m1_wdata` in DW — write data
- `m0_gnt`, `m1_gnt` out 1 — transfer accepted this cycle (combinational)
- `m0_rvalid`, `m1_rvalid` out 1 — read data valid (registered)
- `m0_rdata`, `m1_rdata` out DW — read data (driven from `mem_q`)
- `mem_en` out 1 — to `dpram` `en_A` (write enable)
- `mem_addr` out AW — to `addr_A`
- `mem_data` out DW — to `data_A`
- `mem_q` in DW — from `out_A`; one-cycle registered read

## Operation
- **FSM states:** IDLE, LOCK0, LOCK1.
- **Registers:**
  - `last` (last-served master; reset 1, so m0 wins the first tie)
  - `hold_cnt` (0..HOLD_MAX)
  - `rd_pend[1:0]`
- **Selection:**
  - In LOCKx with `mx_req`=1: x is selected.
  - Otherwise, a lone requester is selected.
  - If both request: the master ≠ `last` is selected (see Configuration).
- **Grant:** `mx_gnt = sel==x && mx_req`. At most one grant per cycle.
- **Memory outputs:** `mem_addr`/`mem_data` mux from the selected master. `mem_en = gnt && we`.
  - With no grant: `mem_addr` = 0, `mem_data` = 0, `mem_en` = 0.
- **Transitions on a grant to x:**
  - `mx_lock`=1, and either the other master is idle or `hold_cnt+1 < HOLD_MAX`: go to LOCKx, `hold_cnt++`.
  - `mx_lock`=1, the other master is requesting, and `hold_cnt+1 == HOLD_MAX`: forced go to IDLE, `hold_cnt`=0, `last`=x. The other master wins the next cycle.
  - `mx_lock`=0: go to IDLE, `hold_cnt`=0, `last`=x.
- **LOCKx with `mx_req`=0:** lock is released. Normal selection applies this cycle; the state follows the grant rules above, or goes to IDLE if there is no grant.
- **`hold_cnt` counting:** counts only while the other master requests. It holds when the other master is idle.
- **Read return:** a granted read sets `rd_pend[x]`. Next cycle, `mx_rvalid`=1 and `mx_rdata = mem_q`.
  - `rdata` for both masters is always `mem_q`. It is meaningful only with `rvalid`.
- **Writes:** no response beyond `gnt`. Data is in memory after the granting edge.
- **Back-to-back reads:** one per cycle, no bubble.

## Timing
- Grant: same cycle as `req` (combinational from state + inputs).
- Read latency: `rvalid` one cycle after `gnt`.
- Write: committed at the granting edge. A read of the same address in the next cycle returns the new data.
- Reset values:
  - state IDLE, `last`=1, `hold_cnt`=0, `rd_pend`=0
  - all `gnt`/`rvalid` low, `mem_en` 0, `mem_addr` 0, `mem_data` 0
- **Reset mid-read:** a read granted the cycle before `reset` returns no `rvalid`.
- **Reset cycle:** while `reset`=1, all grants are suppressed.
- **Simultaneous requests to the same address from both masters:** serialized, never merged.
- **Request not granted:** the master holds `req`/`addr`/`we`/`wdata` stable until `gnt`.

## Configuration
- `MEM_ARB_RR_EN` defined: ties in IDLE resolve round-robin via `last`. The forced handover after HOLD_MAX also goes to the waiting master.
- `MEM_ARB_RR_EN` undefined:
  - Ties resolve fixed-priority to m0, and `last` is unused.
  - The HOLD_MAX handover still applies to LOCK0 and LOCK1, so m1 cannot be starved by a locked m0.
  - m1 can be starved by repeated unlocked m0 requests; this is accepted.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE, LOCK0, LOCK1)
  - default AW=10, DW=16, HOLD_MAX=8 constants
  - master-index type (1 bit)
- Sub-module `rr_pick2`: combinational 2-way picker. Inputs are `req[1:0]` and `last`; output is `sel`. It is compiled to fixed priority when RR is off.
- The top holds the FSM, the counter, `rd_pend`, and the muxes.

## Test plan
- **Single write then read:** m0 write addr 0x005, data 0xBEEF; next cycle m0 read 0x005 → `m0_gnt` both cycles, `m0_rvalid` the cycle after the read with `m0_rdata`=0xBEEF; `m1_rvalid` stays 0.
- **Tie, RR on:** both request reads every cycle with no lock, from reset → grant order m0, m1, m0, m1; each `rvalid` lands on the matching master one cycle later.
- **Lock with starvation bound:** m0 `lock`=1 with continuous reads, m1 requesting → exactly 8 consecutive m0 grants, then m1 granted on cycle 9.
- **Lock with idle partner:** m0 holds lock with 20 reads, m1 idle → 20 consecutive grants; `hold_cnt` stays 0.
- **Reset mid-read:** grant an m1 read, assert `reset` the next cycle → `m1_rvalid`=0, all outputs 0; after release, m0 wins the first tie.
- **Random cross-check:** 160 random writes/reads from both masters against a reference array → every `rdata` matches; never two grants in one cycle.
